prime_collector: RTL and testbench

- Downstream consumer of the prime generator.
- Drives the generator's go input, captures each prime it reports on ready, and buffers results in a small FIFO.
- Presents buffered primes on a valid/ready stream for later stages (UART/display).
- One start command requests a batch of N primes; the generator's own state carries the sequence across batches.

---
 rtl/prime_collector.sv | 190 +++++++++++++++++++
 tb/tb_prime_collector.sv | 359 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/prime_collector.sv
// prime_collector
//   Consumer for the prime generator. Each accepted start requests a batch
//   of `count` primes, one go/ready handshake at a time. Every prime
//   reported on gen_ready is buffered in a small first-word-fall-through
//   FIFO, which is drained on a valid/ready stream. The generator keeps its
//   own position, so consecutive batches continue the prime sequence.
//
// Parameters
//   WIDTH_LOG  log2 of the prime width   (WIDTH = 1 << WIDTH_LOG)
//   DEPTH_LOG  log2 of the FIFO depth    (DEPTH = 1 << DEPTH_LOG)
//
// Ports
//   clk, rst_n     clock (rising edge) and asynchronous active-low reset
//   start, count   batch request; count is latched when start is accepted
//   gen_go         single-cycle go pulse to the generator
//   gen_ready      generator ready / result valid
//   gen_error      generator error, qualified by gen_ready
//   gen_res        generator result
//   out_valid      FIFO non-empty
//   out_ready      consumer accepts the head entry
//   out_data       FIFO head; holds the last popped value while empty
//   busy           batch in progress
//   done           batch complete; held until the next accepted start
//   error          sticky generator error; left only through reset
//   checksum       running XOR of pushed primes for the current batch
//
// Build option
//   PRIME_COLLECTOR_CHECKSUM_EN  when defined, checksum accumulates the XOR
//   of every pushed prime (cleared on reset and on each accepted start);
//   when undefined, checksum is tied to 0 and no accumulator exists.

module prime_collector #(
  parameter int WIDTH_LOG = 4,
  parameter int DEPTH_LOG = 2
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      start,
  input  logic [7:0]                count,
  output logic                      gen_go,
  input  logic                      gen_ready,
  input  logic                      gen_error,
  input  logic [(1<<WIDTH_LOG)-1:0] gen_res,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [(1<<WIDTH_LOG)-1:0] out_data,
  output logic                      busy,
  output logic                      done,
  output logic                      error,
  output logic [(1<<WIDTH_LOG)-1:0] checksum
);

  localparam int WIDTH = 1 << WIDTH_LOG;
  localparam logic [DEPTH_LOG-1:0] PTR_ONE = DEPTH_LOG'(1);
  localparam logic [DEPTH_LOG:0]   OCC_ONE = (DEPTH_LOG+1)'(1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ISSUE,
    S_DLY,
    S_WAIT,
    S_DONE,
    S_ERR
  } state_t;

  state_t               state, state_next;
  logic [7:0]           remaining, remaining_next;
  logic                 push, pop, full;

  logic [WIDTH-1:0]     mem [1<<DEPTH_LOG];
  logic [DEPTH_LOG-1:0] wr_ptr, rd_ptr;
  logic [DEPTH_LOG:0]   occupancy;
  logic [WIDTH-1:0]     last_data;

  // Occupancy can only reach DEPTH (a lone MSB) when the FIFO is full.
  assign full      = occupancy[DEPTH_LOG];
  assign out_valid = (occupancy != '0);
  assign pop       = out_valid && out_ready;
  // Empty FIFO presents the last popped value (0 after reset).
  assign out_data  = out_valid ? mem[rd_ptr] : last_data;

  assign busy  = (state == S_ISSUE) || (state == S_DLY) || (state == S_WAIT);
  assign done  = (state == S_DONE);
  assign error = (state == S_ERR);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= S_IDLE;
      remaining <= '0;
    end else begin
      state     <= state_next;
      remaining <= remaining_next;
    end
  end

  always_comb begin
    state_next     = state;
    remaining_next = remaining;
    gen_go         = 1'b0;
    push           = 1'b0;
    case (state)
      S_IDLE, S_DONE: begin
        if (start) begin
          remaining_next = count;
          state_next     = (count == 8'd0) ? S_DONE : S_ISSUE;
        end
      end
      S_ISSUE: begin
        // Only one request is ever outstanding, so a free slot here
        // guarantees room for the result.
        if (!full && gen_ready) begin
          gen_go     = 1'b1;
          state_next = S_DLY;
        end
      end
      S_DLY: begin
        // gen_ready is still the stale pre-go value this cycle.
        state_next = S_WAIT;
      end
      S_WAIT: begin
        if (gen_ready) begin
          if (gen_error) begin
            state_next = S_ERR;
          end else begin
            push           = 1'b1;
            remaining_next = remaining - 8'd1;
            state_next     = (remaining == 8'd1) ? S_DONE : S_ISSUE;
          end
        end
      end
      S_ERR: begin
        state_next = S_ERR;
      end
      default: begin
        state_next = S_IDLE;
      end
    endcase
  end

  // Storage array carries no reset; entries are only read while valid.
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= gen_res;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      occupancy <= '0;
      last_data <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + PTR_ONE;
      end
      if (pop) begin
        rd_ptr    <= rd_ptr + PTR_ONE;
        last_data <= mem[rd_ptr];
      end
      case ({push, pop})
        2'b10:   occupancy <= occupancy + OCC_ONE;
        2'b01:   occupancy <= occupancy - OCC_ONE;
        default: occupancy <= occupancy;
      endcase
    end
  end

`ifdef PRIME_COLLECTOR_CHECKSUM_EN
  logic             start_accepted;
  logic [WIDTH-1:0] checksum_q;

  assign start_accepted = start && ((state == S_IDLE) || (state == S_DONE));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      checksum_q <= '0;
    end else if (start_accepted) begin
      checksum_q <= '0;
    end else if (push) begin
      checksum_q <= checksum_q ^ gen_res;
    end
  end

  assign checksum = checksum_q;
`else
  assign checksum = '0;
`endif

endmodule

// File: tb/tb_prime_collector.sv
// tb_prime_collector
//   Drives prime_collector with a behavioural prime generator stub (random
//   response latency, optional error on a chosen request) and compares the
//   output stream against a reference list of primes computed by trial
//   division. Directed phases cover reset, batch continuation, FIFO
//   back-pressure, count=0, generator error and reset during a request.

module tb_prime_collector;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic [7:0]  count;
  logic        gen_go;
  logic        gen_ready;
  logic        gen_error;
  logic [15:0] gen_res;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] out_data;
  logic        busy;
  logic        done;
  logic        error;
  logic [15:0] checksum;

  int n_compared   = 0;
  int n_mismatched = 0;

  prime_collector #(.WIDTH_LOG(4), .DEPTH_LOG(2)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .count     (count),
    .gen_go    (gen_go),
    .gen_ready (gen_ready),
    .gen_error (gen_error),
    .gen_res   (gen_res),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .busy      (busy),
    .done      (done),
    .error     (error),
    .checksum  (checksum)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic bit is_prime(input int n);
    if (n < 2) return 1'b0;
    for (int d = 2; d * d <= n; d++) begin
      if (n % d == 0) return 1'b0;
    end
    return 1'b1;
  endfunction

  function automatic int next_prime_after(input int p);
    int c = p + 1;
    while (!is_prime(c)) c++;
    return c;
  endfunction

  task automatic check_output(input string tag, input logic [31:0] observed,
                              input logic [31:0] expected);
    n_compared++;
    assert (observed === expected) else begin
      n_mismatched++;
      $error("[TB] FAIL %s: observed=%0d expected=%0d", tag, observed, expected);
    end
  endtask

  // Generator stub: ready drops at the go edge, result appears after a
  // random number of extra cycles; request number err_at reports an error.
  logic gen_rst;
  logic gen_delivered;
  int   min_lat = 0;
  int   max_lat = 3;
  int   err_at  = 0;
  int   stub_last;
  int   stub_lat;
  int   stub_req;
  bit   stub_busy;

  always @(posedge clk) begin
    if (gen_rst) begin
      gen_ready     <= 1'b1;
      gen_error     <= 1'b0;
      gen_res       <= '0;
      gen_delivered <= 1'b0;
      stub_last     <= 1;
      stub_busy     <= 1'b0;
      stub_req      <= 0;
      stub_lat      <= 0;
    end else begin
      gen_delivered <= 1'b0;
      if (gen_go && gen_ready && !stub_busy) begin
        gen_ready <= 1'b0;
        gen_error <= 1'b0;
        stub_busy <= 1'b1;
        stub_req  <= stub_req + 1;
        stub_lat  <= $urandom_range(max_lat, min_lat);
      end else if (stub_busy) begin
        if (stub_lat == 0) begin
          stub_busy     <= 1'b0;
          gen_ready     <= 1'b1;
          gen_delivered <= 1'b1;
          if (err_at != 0 && stub_req == err_at) begin
            gen_error <= 1'b1;
          end else begin
            gen_res   <= 16'(next_prime_after(stub_last));
            stub_last <= next_prime_after(stub_last);
          end
        end else begin
          stub_lat <= stub_lat - 1;
        end
      end
    end
  end

  // Reference model: the primes the consumer must see, in order.
  int          exp_q[$];
  int          ref_last;
  logic [15:0] ref_xor;
  int          sb_idx = 0;

  always @(negedge clk) begin
    if (!rst_n) begin
      sb_idx = exp_q.size();
    end else if (out_valid && out_ready) begin
      check_output("pop_expected", 32'(sb_idx < exp_q.size()), 32'd1);
      if (sb_idx < exp_q.size()) begin
        check_output("out_data", 32'(out_data), 32'(exp_q[sb_idx]));
        sb_idx++;
      end
    end
  end

  int   go_count  = 0;
  int   go_double = 0;
  logic go_prev   = 1'b0;

  always @(negedge clk) begin
    if (gen_go === 1'b1) begin
      go_count++;
      if (go_prev) go_double++;
    end
    go_prev = (gen_go === 1'b1);
  end

  function automatic logic [15:0] exp_checksum();
`ifdef PRIME_COLLECTOR_CHECKSUM_EN
    return ref_xor;
`else
    return 16'd0;
`endif
  endfunction

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic do_reset();
    rst_n     = 1'b0;
    gen_rst   = 1'b1;
    start     = 1'b0;
    count     = 8'd0;
    out_ready = 1'b0;
    step(3);
    check_output("rst_gen_go",    32'(gen_go),    32'd0);
    check_output("rst_out_valid", 32'(out_valid), 32'd0);
    check_output("rst_out_data",  32'(out_data),  32'd0);
    check_output("rst_busy",      32'(busy),      32'd0);
    check_output("rst_done",      32'(done),      32'd0);
    check_output("rst_error",     32'(error),     32'd0);
    check_output("rst_checksum",  32'(checksum),  32'd0);
    rst_n    = 1'b1;
    gen_rst  = 1'b0;
    ref_last = 1;
    ref_xor  = '0;
    step(1);
  endtask

  // Raise start for one sampled edge; n_push primes are expected from it.
  task automatic apply_stimulus(input int n, input int n_push, input bit accepted);
    start = 1'b1;
    count = 8'(n);
    if (accepted) ref_xor = '0;
    for (int i = 0; i < n_push; i++) begin
      ref_last = next_prime_after(ref_last);
      exp_q.push_back(ref_last);
      ref_xor ^= 16'(ref_last);
    end
    step(1);
    start = 1'b0;
  endtask

  task automatic wait_end(input int budget, input bit random_ready);
    int k = 0;
    while (!(done || error) && k < budget) begin
      if (random_ready) out_ready = 1'($urandom_range(1, 0));
      step(1);
      k++;
    end
    check_output("batch_end_in_time", 32'(done || error), 32'd1);
  endtask

  task automatic wait_drain(input int budget);
    int k = 0;
    out_ready = 1'b1;
    while (out_valid && k < budget) begin
      step(1);
      k++;
    end
    check_output("drain_in_time", 32'(out_valid), 32'd0);
    check_output("no_lost_primes", 32'(exp_q.size() - sb_idx), 32'd0);
  endtask

  int go_base;
  int k;
  int n_rand;

  initial begin
    $display("[TB] prime_collector bench start");
    gen_rst = 1'b1;

    // Fresh batch of five with free-flowing output.
    do_reset();
    out_ready = 1'b1;
    go_base   = go_count;
    apply_stimulus(5, 5, 1'b1);
    wait_end(400, 1'b0);
    check_output("b1_done",  32'(done),  32'd1);
    check_output("b1_busy",  32'(busy),  32'd0);
    check_output("b1_error", 32'(error), 32'd0);
    wait_drain(50);
    check_output("b1_go_pulses", 32'(go_count - go_base), 32'd5);
    check_output("b1_checksum",  32'(checksum), 32'(exp_checksum()));

    // Second batch continues the sequence (13, 17).
    go_base = go_count;
    apply_stimulus(2, 2, 1'b1);
    check_output("b2_done_dropped", 32'(done), 32'd0);
    check_output("b2_busy",         32'(busy), 32'd1);
    wait_end(200, 1'b0);
    check_output("b2_done", 32'(done), 32'd1);
    wait_drain(50);
    check_output("b2_go_pulses", 32'(go_count - go_base), 32'd2);
    check_output("b2_checksum",  32'(checksum), 32'(exp_checksum()));

    // Back-pressure: six requested, FIFO of four fills and stalls issue.
    do_reset();
    out_ready = 1'b0;
    go_base   = go_count;
    apply_stimulus(6, 6, 1'b1);
    k = 0;
    while (!gen_delivered && k < 30) begin
      step(1);
      k++;
    end
    check_output("lat_delivered", 32'(gen_delivered), 32'd1);
    check_output("lat_not_early", 32'(out_valid), 32'd0);
    step(1);
    check_output("lat_valid", 32'(out_valid), 32'd1);
    check_output("lat_data",  32'(out_data),  32'd2);
    k = 0;
    while ((go_count - go_base) < 4 && k < 200) begin
      step(1);
      k++;
    end
    step(30);
    check_output("bp_go_pulses", 32'(go_count - go_base), 32'd4);
    check_output("bp_busy",      32'(busy),   32'd1);
    check_output("bp_gen_go",    32'(gen_go), 32'd0);
    check_output("bp_head",      32'(out_data), 32'd2);
    out_ready = 1'b1;
    wait_end(300, 1'b0);
    check_output("bp_done", 32'(done), 32'd1);
    wait_drain(50);
    check_output("bp_go_total", 32'(go_count - go_base), 32'd6);

    // Random batch with random consumer stalls.
    n_rand  = $urandom_range(10, 3);
    max_lat = 5;
    go_base = go_count;
    apply_stimulus(n_rand, n_rand, 1'b1);
    wait_end(1000, 1'b1);
    check_output("rnd_done", 32'(done), 32'd1);
    wait_drain(50);
    check_output("rnd_go_pulses", 32'(go_count - go_base), 32'(n_rand));
    check_output("rnd_checksum",  32'(checksum), 32'(exp_checksum()));

    // count = 0 completes without touching the generator.
    go_base = go_count;
    apply_stimulus(0, 0, 1'b1);
    check_output("zero_done", 32'(done), 32'd1);
    check_output("zero_busy", 32'(busy), 32'd0);
    step(10);
    check_output("zero_go",       32'(go_count - go_base), 32'd0);
    check_output("zero_valid",    32'(out_valid), 32'd0);
    check_output("zero_checksum", 32'(checksum), 32'(exp_checksum()));
    check_output("go_single_cycle", 32'(go_double), 32'd0);

    // Generator error on the third request.
    do_reset();
    max_lat   = 3;
    err_at    = 3;
    out_ready = 1'b0;
    go_base   = go_count;
    apply_stimulus(5, 2, 1'b1);
    wait_end(300, 1'b0);
    check_output("err_error", 32'(error), 32'd1);
    check_output("err_busy",  32'(busy),  32'd0);
    check_output("err_done",  32'(done),  32'd0);
    apply_stimulus(3, 0, 1'b0);
    step(30);
    check_output("err_start_ignored", 32'(busy),  32'd0);
    check_output("err_sticky",        32'(error), 32'd1);
    check_output("err_go_pulses", 32'(go_count - go_base), 32'd3);
    wait_drain(50);
    check_output("err_checksum", 32'(checksum), 32'(exp_checksum()));

    // Reset while waiting on the third result with two entries buffered.
    err_at = 0;
    do_reset();
    min_lat   = 8;
    max_lat   = 8;
    out_ready = 1'b0;
    go_base   = go_count;
    apply_stimulus(5, 5, 1'b1);
    k = 0;
    while ((go_count - go_base) < 3 && k < 200) begin
      step(1);
      k++;
    end
    step(3);
    check_output("mid_busy_before", 32'(busy), 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    check_output("mid_rst_valid", 32'(out_valid), 32'd0);
    check_output("mid_rst_busy",  32'(busy),      32'd0);
    check_output("mid_rst_done",  32'(done),      32'd0);
    gen_rst = 1'b1;
    step(2);
    rst_n   = 1'b1;
    gen_rst = 1'b0;
    step(3);
    check_output("post_rst_valid", 32'(out_valid), 32'd0);
    check_output("post_rst_go",    32'(gen_go),    32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
    $finish;
  end

endmodule
